// File: rtl/shift_counter_scheduler.sv
// Round-robin scheduler that time-shares one ring/Johnson shift counter between
// two requesters; each job loads a seed, shifts N times and returns the result.
module shift_counter_scheduler #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_steps,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_steps,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_id,
    output logic [WIDTH-1:0] done_value,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             grant0;
    logic             grant1;
    logic             mode_r;
    logic             rr_last;
    logic [CNT_W-1:0] remaining;
    logic             feedback;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration and next-state logic
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid & (~req1_valid | rr_last);
                grant1 = req1_valid & (~req0_valid | ~rr_last);
                if (grant0) begin
                    state_next = (req0_steps != '0) ? RUN : DONE;
                end else if (grant1) begin
                    state_next = (req1_steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (remaining <= CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Readies are forced low while reset is held so nothing looks accepted
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;

    // Ring feeds back the MSB, Johnson feeds back its complement
    assign feedback = q[WIDTH-1] ^ mode_r;

    // Job datapath: load on grant, shift while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            mode_r     <= 1'b0;
            remaining  <= '0;
            done_id    <= 1'b0;
            done_valid <= 1'b0;
            rr_last    <= 1'b1;
        end else begin
            done_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (grant0) begin
                        q         <= req0_data;
                        mode_r    <= req0_mode;
                        remaining <= req0_steps;
                        done_id   <= 1'b0;
                        rr_last   <= 1'b0;
                    end else if (grant1) begin
                        q         <= req1_data;
                        mode_r    <= req1_mode;
                        remaining <= req1_steps;
                        done_id   <= 1'b1;
                        rr_last   <= 1'b1;
                    end
                end
                RUN: begin
                    q <= {q[WIDTH-2:0], feedback};
                    if (remaining != '0) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_value = q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_counter_scheduler.sv
// Directed plus randomized bench for shift_counter_scheduler, checked against
// a rotation-based model of ring and Johnson counting.
module tb_shift_counter_scheduler;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_mode;
    logic [WIDTH-1:0] req0_data;
    logic [CNT_W-1:0] req0_steps;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_mode;
    logic [WIDTH-1:0] req1_data;
    logic [CNT_W-1:0] req1_steps;
    logic             done_valid;
    logic             done_ready;
    logic             done_id;
    logic [WIDTH-1:0] done_value;
    logic [WIDTH-1:0] q;
    logic             busy;

    int n_pass = 0;
    int n_chk  = 0;

    shift_counter_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mode  (req0_mode),
        .req0_data  (req0_data),
        .req0_steps (req0_steps),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mode  (req1_mode),
        .req1_data  (req1_data),
        .req1_steps (req1_steps),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_id    (done_id),
        .done_value (done_value),
        .q          (q),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Ring = rotate W bits; Johnson = rotate the 2W-bit word {q, ~q}, keep the top half
    function automatic logic [WIDTH-1:0] model(input logic mode, input logic [WIDTH-1:0] seed,
                                               input int n);
        int unsigned s, y, r, mask, mask2;
        mask  = (32'd1 << WIDTH) - 32'd1;
        mask2 = (32'd1 << (2 * WIDTH)) - 32'd1;
        s     = 32'(seed);
        if (!mode) begin
            r = 32'(n) % WIDTH;
            y = ((s << r) | (s >> (WIDTH - r))) & mask;
            return WIDTH'(y);
        end
        r = 32'(n) % (2 * WIDTH);
        y = (s << WIDTH) | (~s & mask);
        y = ((y << r) | (y >> (2 * WIDTH - r))) & mask2;
        return WIDTH'(y >> WIDTH);
    endfunction

    task automatic drive(input int id, input logic v, input logic m, input logic [WIDTH-1:0] d,
                         input logic [CNT_W-1:0] s);
        if (id == 0) begin
            req0_valid = v; req0_mode = m; req0_data = d; req0_steps = s;
        end else begin
            req1_valid = v; req1_mode = m; req1_data = d; req1_steps = s;
        end
    endtask

    // Submit one job, follow it cycle by cycle, optionally stall the result
    task automatic job(input int id, input logic m, input logic [WIDTH-1:0] d,
                       input logic [CNT_W-1:0] s, input int bp, output logic [WIDTH-1:0] res);
        int n;
        drive(id, 1'b1, m, d, s);
        #1;
        n = 0;
        while (((id == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 60) begin
            cyc();
            n++;
        end
        chk("grant", 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
        chk("grant_excl", 32'((id == 0) ? req1_ready : req0_ready), 32'd0);
        cyc();
        drive(id, 1'b0, ~m, ~d, ~s);
        for (int k = 0; k <= int'(s); k++) begin
            chk("q_trace", 32'(q), 32'(model(m, d, k)));
            chk("done_valid", 32'(done_valid), 32'(k == int'(s)));
            chk("busy_run", 32'(busy), 32'd1);
            chk("ready_run", 32'({req0_ready, req1_ready}), 32'd0);
            if (k < int'(s)) begin
                done_ready = 1'($urandom_range(0, 1));
                cyc();
            end
        end
        done_ready = 1'b0;
        chk("done_value", 32'(done_value), 32'(model(m, d, int'(s))));
        chk("done_id", 32'(done_id), 32'(id));
        for (int b = 0; b < bp; b++) begin
            cyc();
            chk("bp_valid", 32'(done_valid), 32'd1);
            chk("bp_value", 32'(done_value), 32'(model(m, d, int'(s))));
            chk("bp_id", 32'(done_id), 32'(id));
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        res = done_value;
        done_ready = 1'b1;
        cyc();
        done_ready = 1'b0;
        chk("done_clear", 32'(done_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] rd;
        logic [CNT_W-1:0] rs;
        logic             rm;
        int               rid;
        int               n;
        int               accepts;
        int               expect_id;
        int               bad;

        rst_n = 1'b1; done_ready = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;

        // Reset with both requesters waiting
        drive(0, 1'b1, 1'b0, 4'b0001, 4'd3);
        drive(1, 1'b1, 1'b1, 4'b0000, 4'd5);
        repeat (2) cyc();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready0", 32'(req0_ready), 32'd1);
        chk("rel_ready1", 32'(req1_ready), 32'd0);

        job(0, 1'b0, 4'b0001, 4'd3, 0, res);
        chk("ring3_result", 32'(res), 32'b1000);
        chk("bubble_ready1", 32'(req1_ready), 32'd1);
        job(1, 1'b1, 4'b0000, 4'd5, 0, res);
        chk("johnson5_result", 32'(res), 32'b1110);

        // Both requesters continuously valid: grants must alternate
        done_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 4'b0011, 4'd1);
        drive(1, 1'b1, 1'b1, 4'b0101, 4'd2);
        #1;
        accepts = 0; expect_id = 0; n = 0;
        while (accepts < 3 && n < 100) begin
            if (req0_ready || req1_ready) begin
                chk("alt_onehot", 32'(req0_ready) + 32'(req1_ready), 32'd1);
                chk("alt_id", 32'(req1_ready), 32'(expect_id));
                expect_id ^= 1;
                accepts++;
            end
            cyc();
            n++;
            if (accepts == 3) begin
                drive(0, 1'b0, 1'b0, '0, '0);
                drive(1, 1'b0, 1'b0, '0, '0);
            end
        end
        chk("alt_count", 32'(accepts), 32'd3);
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        chk("alt_drain", 32'(busy), 32'd0);
        done_ready = 1'b0;

        // Wrap-around and zero-length jobs
        job(0, 1'b0, 4'b1010, 4'd4, 0, res);
        chk("ring_wrap", 32'(res), 32'b1010);
        job(1, 1'b1, 4'b0000, 4'd8, 0, res);
        chk("johnson_wrap", 32'(res), 32'b0000);
        job(0, 1'b0, 4'b0110, 4'd0, 0, res);
        chk("zero_steps", 32'(res), 32'b0110);

        // Result backpressure
        job(1, 1'b1, 4'b1001, 4'd6, 3, res);
        chk("bp_result", 32'(res), 32'(model(1'b1, 4'b1001, 6)));

        // Withdrawn request during RUN, then reset mid-job
        drive(0, 1'b1, 1'b0, 4'b0011, 4'd10);
        #1;
        n = 0;
        while (req0_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("mr_grant", 32'(req0_ready), 32'd1);
        cyc();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b1, 4'b1111, 4'd7);
        cyc();
        chk("wd_ready_a", 32'(req1_ready), 32'd0);
        cyc();
        chk("wd_ready_b", 32'(req1_ready), 32'd0);
        drive(1, 1'b0, 1'b0, '0, '0);
        chk("mr_busy_pre", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_q", 32'(q), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done_valid", 32'(done_valid), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (done_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("mr_no_result", 32'(bad), 32'd0);

        // Randomized jobs
        for (int j = 0; j < 16; j++) begin
            rid = int'($urandom_range(0, 1));
            rm  = 1'($urandom_range(0, 1));
            rd  = WIDTH'($urandom);
            rs  = CNT_W'($urandom);
            job(rid, rm, rd, rs, int'($urandom_range(0, 2)), res);
            chk("rand_result", 32'(res), 32'(model(rm, rd, int'(rs))));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
